// File: rtl/subbytes_serial_if.sv
// Handshake bundle for the byte-serial SubBytes sequencer: state in, result out.
interface subbytes_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/subbytes_serial.sv
// Byte-serial AES SubBytes sequencer driving one shared external S-box with
// SBOX_LAT cycles of latency; collects the 16 substituted bytes into one result.
module subbytes_serial #(
    parameter int unsigned SBOX_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    subbytes_serial_if.slave   bus,
    output logic [7:0]         o_sbox_in,
    input  logic [7:0]         i_sbox_out,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [127:0] r_buf;
    logic [127:0] r_res;
    logic [3:0]   r_cnt;
    logic         w_accept;
    logic         w_feed;
    logic         w_tag_v;
    logic [3:0]   w_tag_idx;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_feed   = (r_state == S_FEED);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_FEED;
            S_FEED:  if (r_cnt == 4'd15) w_next = (SBOX_LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (w_tag_v && (w_tag_idx == 4'd15)) w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_buf <= bus.in_state;
                r_cnt <= '0;
            end else if (w_feed) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Each fed byte carries {valid, index} alongside it so the S-box result
    // lands in the right result slot regardless of latency.
    if (SBOX_LAT == 0) begin : g_comb
        assign w_tag_v   = w_feed;
        assign w_tag_idx = r_cnt;
    end else begin : g_pipe
        for (genvar g = 0; g < SBOX_LAT; g++) begin : g_stage
            logic [4:0] r_tag;
            logic [4:0] w_tag_d;
            if (g == 0) begin : g_src
                assign w_tag_d = {w_feed, r_cnt};
            end else begin : g_chain
                assign w_tag_d = g_stage[g-1].r_tag;
            end
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) r_tag <= '0;
                else          r_tag <= w_tag_d;
            end
        end
        assign {w_tag_v, w_tag_idx} = g_stage[SBOX_LAT-1].r_tag;
    end

    // Byte k sits at bits [127-8k -: 8]; for a 4-bit k, 15-k is simply ~k.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res <= '0;
        end else if (w_tag_v) begin
            r_res[{~w_tag_idx, 3'b000} +: 8] <= i_sbox_out;
        end
    end

    assign o_sbox_in     = w_feed ? r_buf[{~r_cnt, 3'b000} +: 8] : '0;
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_state = r_res;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_subbytes_serial.sv
// Self-checking bench: three sequencers (S-box latency 0, 1, 3) fed by a
// behavioural GF(2^8) S-box, checked against a bytewise SubBytes reference.
module tb_subbytes_serial;

    logic clk;
    logic rst_n;

    subbytes_serial_if b0 ();
    subbytes_serial_if b1 ();
    subbytes_serial_if b3 ();

    logic [7:0] sb0, sb1, sb3;
    logic [7:0] so0, so1, so3;
    logic       bz0, bz1, bz3;
    logic [7:0] p1;
    logic [7:0] p3 [3];

    int n_tests = 0;
    int n_fail  = 0;

    subbytes_serial #(.SBOX_LAT(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b0),
        .o_sbox_in(sb0), .i_sbox_out(so0), .o_busy(bz0)
    );
    subbytes_serial #(.SBOX_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b1),
        .o_sbox_in(sb1), .i_sbox_out(so1), .o_busy(bz1)
    );
    subbytes_serial #(.SBOX_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b3),
        .o_sbox_in(sb3), .i_sbox_out(so3), .o_busy(bz3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AES S-box from its definition: multiplicative inverse in GF(2^8) mod
    // x^8+x^4+x^3+x+1, followed by the affine transform with constant 0x63.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++)
                if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] s, input int k);
        return s[127 - 8*k -: 8];
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = sbox_f(byte_of(s, k));
        return r;
    endfunction

    assign so0 = sbox_f(sb0);
    always @(posedge clk) p1 <= sbox_f(sb1);
    assign so1 = p1;
    always @(posedge clk) begin
        p3[0] <= sbox_f(sb3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign so3 = p3[2];

    task automatic drive(input int w, input logic v, input logic [127:0] s, input logic ordy);
        case (w)
            0: begin b0.in_valid = v; b0.in_state = s; b0.out_ready = ordy; end
            1: begin b1.in_valid = v; b1.in_state = s; b1.out_ready = ordy; end
            default: begin b3.in_valid = v; b3.in_state = s; b3.out_ready = ordy; end
        endcase
    endtask

    function automatic logic ir(input int w);
        return (w == 0) ? b0.in_ready : (w == 1) ? b1.in_ready : b3.in_ready;
    endfunction
    function automatic logic ov(input int w);
        return (w == 0) ? b0.out_valid : (w == 1) ? b1.out_valid : b3.out_valid;
    endfunction
    function automatic logic [127:0] os(input int w);
        return (w == 0) ? b0.out_state : (w == 1) ? b1.out_state : b3.out_state;
    endfunction
    function automatic logic [7:0] sb(input int w);
        return (w == 0) ? sb0 : (w == 1) ? sb1 : sb3;
    endfunction
    function automatic logic bz(input int w);
        return (w == 0) ? bz0 : (w == 1) ? bz1 : bz3;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge one cycle
    // after the output handshake, so calls chain back-to-back.
    task automatic do_block(input int w, input logic [127:0] st, input logic [127:0] exp,
                            input int stall, input string nm);
        int         n;
        logic [7:0] exp_sb;
        logic [7:0] bad_a = 8'h00;
        logic [7:0] bad_e = 8'h00;
        bit         seen_bad = 0;
        logic [127:0] other = ~st;
        chk({nm, " in_ready before accept"}, ir(w), 1);
        drive(w, 1'b1, st, stall == 0);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, other, stall == 0);
        n = 1;
        while (!ov(w) && n < 64) begin
            exp_sb = (n <= 16) ? byte_of(st, n - 1) : 8'h00;
            if (!seen_bad && sb(w) !== exp_sb) begin
                seen_bad = 1; bad_a = sb(w); bad_e = exp_sb;
            end
            @(negedge clk);
            n++;
        end
        chk({nm, " sbox_in sequence"}, bad_a, bad_e);
        chk({nm, " out_valid cycle"}, n, 17 + w);
        chk({nm, " out_state"}, os(w), exp);
        chk({nm, " busy in done"}, bz(w), 1);
        for (int i = 0; i < stall; i++) begin
            chk({nm, " stall out_valid"}, ov(w), 1);
            chk({nm, " stall in_ready"}, ir(w), 0);
            chk({nm, " stall out_state"}, os(w), exp);
            if (i == 1) drive(w, 1'b1, other, 1'b0);
            if (i == 2) drive(w, 1'b0, other, 1'b0);
            @(negedge clk);
        end
        if (stall > 0) begin
            drive(w, 1'b0, other, 1'b1);
            chk({nm, " post-stall out_state"}, os(w), exp);
            chk({nm, " post-stall out_valid"}, ov(w), 1);
        end
        @(negedge clk);
        chk({nm, " in_ready after handshake"}, ir(w), 1);
        chk({nm, " busy after handshake"}, bz(w), 0);
        chk({nm, " out_valid after handshake"}, ov(w), 0);
    endtask

    typedef struct {
        logic [127:0] st;
        logic [127:0] exp;
        int           stall;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] st;
        vecs[0] = '{128'h0, 128'h63636363636363636363636363636363, 0};
        vecs[1] = '{128'h00102030405060708090a0b0c0d0e0f0,
                    128'h63cab7040953d051cd60e0e7ba70e18c, 0};
        vecs[2] = '{128'h00112233445566778899aabbccddeeff,
                    128'h638293c31bfc33f5c4eeacea4bc12816, 0};
        vecs[3] = '{128'h00102030405060708090a0b0c0d0e0f0,
                    128'h63cab7040953d051cd60e0e7ba70e18c, 5};

        rst_n = 1'b0;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        drive(3, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset in_ready", ir(1), 1);
        chk("reset out_valid", ov(1), 0);
        chk("reset busy", bz(1), 0);
        chk("reset sbox_in", sb(1), 0);
        chk("reset out_state", os(1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            do_block(1, vecs[i].st, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));

        // Abort a block while byte 7 is on the S-box input.
        st = 128'hdeadbeef0123456789abcdeffedcba98;
        drive(1, 1'b1, st, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, '0, 1'b1);
        repeat (7) @(negedge clk);
        chk("midreset byte7 on sbox_in", sb(1), byte_of(st, 7));
        chk("midreset busy before", bz(1), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", ov(1), 0);
        chk("midreset busy", bz(1), 0);
        chk("midreset sbox_in", sb(1), 0);
        chk("midreset in_ready", ir(1), 1);
        @(negedge clk);
        rst_n = 1'b1;
        st = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        do_block(1, st, ref_sub(st), 0, "post-reset");

        for (int r = 0; r < 20; r++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            do_block(1, st, ref_sub(st), 0, $sformatf("lat1 rand%0d", r));
        end
        for (int i = 0; i < 100; i++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            do_block(0, st, ref_sub(st), 0, $sformatf("lat0 rand%0d", i));
        end
        for (int i = 0; i < 100; i++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            do_block(3, st, ref_sub(st), 0, $sformatf("lat3 rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
